// File: rtl/alu_cond_writeback.sv
// rtl/alu_cond_writeback.sv - ALU result consumer: NZCV flag register, condition check, 2-entry writeback FIFO
module alu_cond_writeback #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_n,
    input  logic             in_z,
    input  logic             in_c,
    input  logic             in_v,
    input  logic             in_set_flags,
    input  logic [3:0]       in_cond,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_we,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] skip_cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] res_q [2];
    logic [RD_W-1:0]  rd_q  [2];
    logic [1:0]       we_q;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] skip_q, skip_d;

    logic accept, pop, pass;
    logic f_n, f_z, f_c, f_v;

    assign {f_n, f_z, f_c, f_v} = flags_q;

    assign in_ready   = (count_q != 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign accept     = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign out_result = res_q[rd_ptr_q];
    assign out_rd     = rd_q[rd_ptr_q];
    assign out_we     = we_q[rd_ptr_q];
    assign flags      = flags_q;
    assign skip_cnt   = skip_q;

    // Condition is judged against the flags as they stand before this op.
    always_comb begin
        pass = 1'b0;
        case (in_cond)
            4'd0:  pass = f_z;
            4'd1:  pass = !f_z;
            4'd2:  pass = f_c;
            4'd3:  pass = !f_c;
            4'd4:  pass = f_n;
            4'd5:  pass = !f_n;
            4'd6:  pass = f_v;
            4'd7:  pass = !f_v;
            4'd8:  pass = f_c & !f_z;
            4'd9:  pass = !f_c | f_z;
            4'd10: pass = (f_n == f_v);
            4'd11: pass = (f_n != f_v);
            4'd12: pass = !f_z & (f_n == f_v);
            4'd13: pass = f_z | (f_n != f_v);
            4'd14: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        flags_d  = flags_q;
        skip_d   = skip_q;
        if (accept) wr_ptr_d = !wr_ptr_q;
        if (pop)    rd_ptr_d = !rd_ptr_q;
        if (accept && !pop)      count_d = count_q + 2'd1;
        else if (!accept && pop) count_d = count_q - 2'd1;
        if (accept && pass && in_set_flags) flags_d = {in_n, in_z, in_c, in_v};
        if (accept && !pass && (skip_q != CNT_MAX)) skip_d = skip_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            flags_q  <= 4'd0;
            skip_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            skip_q   <= skip_d;
        end
    end

    // Failed ops are queued too (we=0) so writeback order matches issue order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q[0] <= '0;
            res_q[1] <= '0;
            rd_q[0]  <= '0;
            rd_q[1]  <= '0;
            we_q     <= 2'b00;
        end else if (accept) begin
            res_q[wr_ptr_q] <= in_result;
            rd_q[wr_ptr_q]  <= in_rd;
            we_q[wr_ptr_q]  <= pass;
        end
    end
endmodule

// File: tb/tb_alu_cond_writeback.sv
// tb/tb_alu_cond_writeback.sv - directed bench with queue-based reference model for alu_cond_writeback
module tb_alu_cond_writeback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_result = '0;
    logic        in_n = 1'b0, in_z = 1'b0, in_c = 1'b0, in_v = 1'b0;
    logic        in_set_flags = 1'b0;
    logic [3:0]  in_cond = 4'd14;
    logic [4:0]  in_rd = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_we;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [3:0]  flags;
    logic [15:0] skip_cnt;

    logic        s_in_ready, s_out_valid, s_out_we;
    logic [31:0] s_out_result;
    logic [4:0]  s_out_rd;
    logic [3:0]  s_flags;
    logic [3:0]  s_skip_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_cond_writeback dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
        .in_set_flags(in_set_flags), .in_cond(in_cond), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .flags(flags), .skip_cnt(skip_cnt)
    );

    // Narrow-counter copy on the same inputs, used to reach saturation quickly.
    alu_cond_writeback #(.WIDTH(32), .RD_W(5), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_result(in_result), .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
        .in_set_flags(in_set_flags), .in_cond(in_cond), .in_rd(in_rd),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
        .out_rd(s_out_rd), .out_we(s_out_we), .flags(s_flags), .skip_cnt(s_skip_cnt)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } entry_t;

    entry_t      mq[$];
    logic [3:0]  mflags = 4'd0;
    int          mskip = 0;
    int          mskip4 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return cc[0] ? !base : base;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mflags = 4'd0;
                mskip  = 0;
                mskip4 = 0;
            end else begin
                automatic bit acc = in_valid && (mq.size() < 2);
                automatic bit pp  = (mq.size() > 0) && out_ready;
                automatic bit p   = cond_ok(in_cond, mflags);
                if (pp) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back('{res: in_result, rd: in_rd, we: p});
                    if (p && in_set_flags) mflags = {in_n, in_z, in_c, in_v};
                    if (!p) begin
                        if (mskip < 65535) mskip++;
                        if (mskip4 < 15) mskip4++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("in_ready", in_ready, mq.size() != 2);
            check("out_valid", out_valid, mq.size() != 0);
            check("flags", flags, mflags);
            check("skip_cnt", skip_cnt, mskip);
            check("s_skip_cnt", s_skip_cnt, mskip4);
            if (mq.size() != 0) begin
                check("out_result", out_result, mq[0].res);
                check("out_rd", out_rd, mq[0].rd);
                check("out_we", out_we, mq[0].we);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] cc, input logic sf, input logic [3:0] nzcv,
                      input logic [31:0] res, input logic [4:0] rd);
        in_valid = 1'b1;
        in_cond = cc;
        in_set_flags = sf;
        {in_n, in_z, in_c, in_v} = nzcv;
        in_result = res;
        in_rd = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_set_flags = 1'b0;
    endtask

    initial begin
        #2;
        check("rst out_valid", out_valid, 0);
        check("rst flags", flags, 0);
        check("rst skip", skip_cnt, 0);
        check("rst out_result", out_result, 0);
        check("rst out_rd", out_rd, 0);
        check("rst out_we", out_we, 0);
        check("rst in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        op(4'd14, 1'b1, 4'b1000, 32'h8000_0000, 5'd3);
        tick();
        idle();
        check("t1 out_valid", out_valid, 1);
        check("t1 out_result", out_result, 32'h8000_0000);
        check("t1 out_rd", out_rd, 3);
        check("t1 out_we", out_we, 1);
        check("t1 flags", flags, 4'b1000);
        tick();

        op(4'd14, 1'b1, 4'b0100, 32'h11, 5'd1);
        tick();
        op(4'd0, 1'b0, 4'b0000, 32'h22, 5'd2);
        tick();
        check("eq we", out_we, 1);
        check("eq flags", flags, 4'b0100);
        op(4'd1, 1'b0, 4'b0000, 32'h33, 5'd3);
        tick();
        idle();
        check("ne we", out_we, 0);
        check("ne skip", skip_cnt, 1);
        tick();

        op(4'd14, 1'b1, 4'b0000, 32'h44, 5'd4);
        tick();
        op(4'd0, 1'b0, 4'b0000, 32'h55, 5'd5);
        tick();
        idle();
        check("b2b result", out_result, 32'h55);
        check("b2b we", out_we, 0);
        check("b2b skip", skip_cnt, 2);
        tick();
        tick();

        out_ready = 1'b0;
        op(4'd14, 1'b0, 4'b0000, 32'hA, 5'd10);
        tick();
        op(4'd14, 1'b0, 4'b0000, 32'hB, 5'd11);
        tick();
        check("full in_ready", in_ready, 0);
        op(4'd14, 1'b0, 4'b0000, 32'hC, 5'd12);
        tick();
        check("held in_ready", in_ready, 0);
        check("held head", out_result, 32'hA);
        out_ready = 1'b1;
        tick();
        check("drain1", out_result, 32'hB);
        check("drain1 in_ready", in_ready, 1);
        tick();
        idle();
        check("drain2", out_result, 32'hC);
        tick();
        check("drained", out_valid, 0);

        for (int f = 0; f < 16; f += 5) begin
            op(4'd14, 1'b1, f[3:0], 32'h100 + f, 5'd0);
            tick();
            for (int cc = 0; cc < 16; cc++) begin
                op(cc[3:0], 1'b0, 4'b0000, 32'h200 + cc, cc[4:0]);
                tick();
            end
            idle();
            tick();
        end

        out_ready = 1'b0;
        op(4'd14, 1'b1, 4'b1111, 32'h300, 5'd7);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op(4'd14, 1'b0, 4'b0000, 32'h400 + i, i[4:0]);
            tick();
            check("pp out_valid", out_valid, 1);
            check("pp in_ready", in_ready, 1);
        end
        check("pp flags", flags, 4'b1111);
        rst_n = 1'b0;
        #1;
        check("arst out_valid", out_valid, 0);
        check("arst flags", flags, 0);
        check("arst skip", skip_cnt, 0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        op(4'd14, 1'b1, 4'b0101, 32'h500, 5'd1);
        tick();
        for (int i = 0; i < 20; i++) begin
            op(4'd15, 1'b1, 4'b1010, 32'h600 + i, 5'd2);
            tick();
        end
        idle();
        check("nv flags", flags, 4'b0101);
        check("nv skip", skip_cnt, 20);
        check("sat skip4", s_skip_cnt, 4'hF);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
